// File: rtl/lsu_mem_master_if.sv
// Request/response and data-memory signals of the load/store unit.
// The master modport is the LSU side. The slave modport is the core plus memory side.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  resp_err_code;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_err_code,
           mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_err_code,
           mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32I load/store unit that drives a word-addressed data memory.
// It accepts one request at a time. Loads are extracted and extended from a single word read.
// Sub-word stores are done as read-modify-write. Faulting requests answer without touching memory.
module lsu_mem_master #(
  parameter int MEM_WORDS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_mem_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

  localparam logic [30:0] LP_WORDS = 31'(MEM_WORDS);

  state_t      r_state, w_next;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [29:0] r_widx;
  logic [31:0] r_sdata;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [1:0]  r_code;

  logic        w_accept;
  logic        w_f3_bad, w_misal, w_oor;
  logic [1:0]  w_code;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [4:0]  w_sh;
  logic [31:0] w_mask, w_merge;

  assign w_accept = bus.req_valid && bus.req_ready;

  // Legality checks on the incoming request. Illegal funct3 wins, then misalignment, then range.
  always_comb begin
    w_code = 2'b00;
    if (bus.req_we) w_f3_bad = (bus.req_funct3 > 3'd2);
    else            w_f3_bad = (bus.req_funct3 == 3'd3) || (bus.req_funct3[2:1] == 2'b11);
    w_misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
              ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    w_oor   = ({1'b0, bus.req_addr[31:2]} >= LP_WORDS);
    if (w_f3_bad)     w_code = 2'b11;
    else if (w_misal) w_code = 2'b01;
    else if (w_oor)   w_code = 2'b10;
  end

  // Load extraction (little-endian lanes) and the sub-word store merge.
  always_comb begin
    w_byte = bus.mem_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_f3)
      3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_ext = {{16{w_half[15]}}, w_half};
      3'd4:    w_ext = {24'd0, w_byte};
      3'd5:    w_ext = {16'd0, w_half};
      default: w_ext = bus.mem_rdata;
    endcase
    if (r_f3[1:0] == 2'b00) begin
      w_sh   = {r_off, 3'b000};
      w_mask = 32'h0000_00FF << w_sh;
    end else begin
      w_sh   = {r_off[1], 4'b0000};
      w_mask = 32'h0000_FFFF << w_sh;
    end
    w_merge = (bus.mem_rdata & ~w_mask) | ((r_sdata << w_sh) & w_mask);
  end

  // State register. Reset aborts any in-flight access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state. SW goes straight to WR. Loads and SB/SH read first. Faults go straight to RESP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
              if (w_code != 2'b00)                                   w_next = RESP;
              else if (bus.req_we && (bus.req_funct3[1:0] == 2'b10)) w_next = WR;
              else                                                   w_next = RD;
            end
      RD:      w_next = RD_WAIT;
      RD_WAIT: w_next = r_we ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture, merge data and response registers.
  // Response fields change only on entry to RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_f3        <= 3'd0;
      r_off       <= 2'd0;
      r_widx      <= 30'd0;
      r_sdata     <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
      r_code      <= 2'b00;
    end else begin
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_f3    <= bus.req_funct3;
        r_off   <= bus.req_addr[1:0];
        r_widx  <= bus.req_addr[31:2];
        r_sdata <= bus.req_wdata;
        if (w_code != 2'b00) begin
          r_err   <= 1'b1;
          r_code  <= w_code;
          r_rdata <= 32'd0;
        end else if (bus.req_we) begin
          r_mem_wdata <= bus.req_wdata;
        end
      end
      if (r_state == RD_WAIT) begin
        if (r_we) r_mem_wdata <= w_merge;
        else begin
          r_rdata <= w_ext;
          r_err   <= 1'b0;
          r_code  <= 2'b00;
        end
      end
      if (r_state == WR) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b0;
        r_code  <= 2'b00;
      end
    end
  end

  assign bus.req_ready     = (r_state == IDLE);
  assign bus.resp_valid    = (r_state == RESP);
  assign bus.resp_rdata    = r_rdata;
  assign bus.resp_err      = r_err;
  assign bus.resp_err_code = r_code;
  assign bus.mem_we        = (r_state == WR);
  assign bus.mem_addr      = ((r_state == RD) || (r_state == RD_WAIT) || (r_state == WR)) ?
                             {2'b00, r_widx} : 32'd0;
  assign bus.mem_wdata     = r_mem_wdata;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a registered-read word memory model.
module tb_lsu_mem_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if bus ();

  lsu_mem_master #(.MEM_WORDS(20)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Data memory: registered read, write on the edge that ends WR.
  logic [31:0] mem [0:31];
  logic [31:0] r_mem_rd = 32'd0;
  logic        mem_init = 1'b0;
  assign bus.mem_rdata = r_mem_rd;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
      mem[1]  <= 32'h1122_3344;
      mem[8]  <= 32'hA5A5_A5A5;
      mem[19] <= 32'hCAFE_F00D;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
      r_mem_rd <= mem[bus.mem_addr[4:0]];
    end
  end

  // Monitors: acceptances, responses and write pulses.
  int          cyc = 0, acc_cnt = 0, acc_cyc = 0, resp_cnt = 0, we_cnt = 0;
  logic [31:0] last_rdata = 32'd0, we_addr = 32'd0, we_data = 32'd0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.req_valid && bus.req_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
  end
  always @(negedge clk) begin
    if (bus.resp_valid) begin
      resp_cnt   <= resp_cnt + 1;
      last_rdata <= bus.resp_rdata;
    end
    if (bus.mem_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= bus.mem_addr;
      we_data <= bus.mem_wdata;
    end
  end

  // One request from IDLE. Returns the response and the number of edges from acceptance to RESP.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic err, output logic [1:0] code);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    rd = bus.resp_rdata; err = bus.resp_err; code = bus.resp_err_code;
    @(posedge clk); #1;
  endtask

  // Runs one request and checks latency, data, error and the write-pulse count.
  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                     input logic [31:0] exp_rd, input logic [1:0] exp_code, input int exp_we);
    int lat; logic [31:0] rd; logic err; logic [1:0] code; int w0;
    w0 = we_cnt;
    do_req(we, f3, addr, wd, lat, rd, err, code);
    chk({tag, "_lat"},   32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"},   {31'd0, err}, {31'd0, exp_code != 2'b00});
    chk({tag, "_code"},  {30'd0, code}, {30'd0, exp_code});
    chk({tag, "_wecnt"}, 32'(we_cnt - w0), 32'(exp_we));
  endtask

  logic [2:0]  s_f3 [4] = '{3'd2, 3'd2, 3'd0, 3'd2};
  logic        s_we [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] s_ad [4] = '{32'h10, 32'h10, 32'h11, 32'h10};
  logic [31:0] s_wd [4] = '{32'h1234_5678, 32'h0, 32'hAA, 32'h0};
  int          s_gap[4] = '{0, 3, 4, 5};

  initial begin
    int a0, t, prev, r0, w0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    @(posedge clk); #1; mem_init = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready",  {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rvalid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_mwe",    {31'd0, bus.mem_we}, 32'd0);
    chk("rst_maddr",  bus.mem_addr, 32'd0);
    chk("rst_mwdata", bus.mem_wdata, 32'd0);
    chk("rst_rdata",  bus.resp_rdata, 32'd0);
    chk("rst_code",   {29'd0, bus.resp_err, bus.resp_err_code}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run("sw8", 1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF, 1, 32'h0, 2'b00, 1);
    chk("sw8_addr", we_addr, 32'd2);
    chk("sw8_data", we_data, 32'hDEAD_BEEF);
    run("lw8", 1'b0, 3'd2, 32'h8, 32'h0, 2, 32'hDEAD_BEEF, 2'b00, 0);

    run("sb5", 1'b1, 3'd0, 32'h5, 32'h0000_0080, 3, 32'h0, 2'b00, 1);
    chk("sb5_addr", we_addr, 32'd1);
    chk("sb5_data", we_data, 32'h1122_8044);
    chk("sb5_mem",  mem[1], 32'h1122_8044);
    run("lb5",  1'b0, 3'd0, 32'h5, 32'h0, 2, 32'hFFFF_FF80, 2'b00, 0);
    run("lbu5", 1'b0, 3'd4, 32'h5, 32'h0, 2, 32'h0000_0080, 2'b00, 0);
    run("lw4",  1'b0, 3'd2, 32'h4, 32'h0, 2, 32'h1122_8044, 2'b00, 0);

    run("sh6", 1'b1, 3'd1, 32'h6, 32'h0000_BEEF, 3, 32'h0, 2'b00, 1);
    chk("sh6_data", we_data, 32'hBEEF_8044);
    run("lh6",  1'b0, 3'd1, 32'h6, 32'h0, 2, 32'hFFFF_BEEF, 2'b00, 0);
    run("lhu6", 1'b0, 3'd5, 32'h6, 32'h0, 2, 32'h0000_BEEF, 2'b00, 0);
    run("lb4",  1'b0, 3'd0, 32'h4, 32'h0, 2, 32'h0000_0044, 2'b00, 0);
    run("lw4c", 1'b0, 3'd2, 32'h4C, 32'h0, 2, 32'hCAFE_F00D, 2'b00, 0);

    run("e_lw3",   1'b0, 3'd2, 32'h3,  32'h0, 0, 32'h0, 2'b01, 0);
    run("e_sw50",  1'b1, 3'd2, 32'h50, 32'h1, 0, 32'h0, 2'b10, 0);
    run("e_ld3",   1'b0, 3'd3, 32'h0,  32'h0, 0, 32'h0, 2'b11, 0);
    run("e_sh7",   1'b1, 3'd1, 32'h7,  32'h1, 0, 32'h0, 2'b01, 0);
    run("e_st3",   1'b1, 3'd3, 32'h51, 32'h1, 0, 32'h0, 2'b11, 0);
    run("e_lh51",  1'b0, 3'd1, 32'h51, 32'h0, 0, 32'h0, 2'b01, 0);
    run("e_lb50",  1'b0, 3'd0, 32'h50, 32'h0, 0, 32'h0, 2'b10, 0);

    // req_valid held high across a mixed stream.
    r0 = resp_cnt; prev = 0;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.req_we = s_we[k]; bus.req_funct3 = s_f3[k];
      bus.req_addr = s_ad[k]; bus.req_wdata = s_wd[k];
      a0 = acc_cnt; t = 0;
      while (acc_cnt == a0 && t < 20) begin
        @(posedge clk); #1; t++;
      end
      chk("b2b_accept", {31'd0, acc_cnt != a0}, 32'd1);
      chk("b2b_busy", {31'd0, bus.req_ready}, 32'd0);
      if (k > 0) chk("b2b_gap", 32'(acc_cyc - prev), 32'(s_gap[k]));
      prev = acc_cyc;
    end
    bus.req_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("b2b_resps", 32'(resp_cnt - r0), 32'd4);
    chk("b2b_lw",    last_rdata, 32'h1234_AA78);

    // Reset while the SB is in WR.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h21; bus.req_wdata = 32'h55;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    t = 0;
    while (!bus.mem_we && t < 10) begin
      @(negedge clk); t++;
    end
    chk("rw_reach_wr", {31'd0, bus.mem_we}, 32'd1);
    rst_n = 1'b0; #1;
    chk("rw_mwe",    {31'd0, bus.mem_we}, 32'd0);
    chk("rw_maddr",  bus.mem_addr, 32'd0);
    chk("rw_mwdata", bus.mem_wdata, 32'd0);
    chk("rw_rvalid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rw_rdata",  bus.resp_rdata, 32'd0);
    chk("rw_ready",  {31'd0, bus.req_ready}, 32'd1);
    r0 = resp_cnt; w0 = we_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("rw_noresp", 32'(resp_cnt - r0), 32'd0);
    chk("rw_nowe",   32'(we_cnt - w0), 32'd0);
    chk("rw_mem",    mem[8], 32'hA5A5_A5A5);
    chk("rw_ready2", {31'd0, bus.req_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
